// File: rtl/inst_mem_responder.sv
// inst_mem_responder: responder end of the instruction fetch channel.
// Accepts one PC request at a time, looks up a word-addressed instruction
// array and returns the word on the response handshake after LATENCY+1 edges.
// Build option: define INST_MEM_RAND_DELAY_EN to add 0..3 pseudo-random wait
// cycles per request and to randomly throttle Inst_Req_Ready while idle.

module inst_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2,
  parameter     INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           PC,
  input  logic                  Inst_Req_Valid,
  output logic                  Inst_Req_Ready,
  output logic [31:0]           Instruction,
  output logic                  Inst_Valid,
  input  logic                  Inst_Ready,
  input  logic                  Load_En,
  input  logic [ADDR_WIDTH-1:0] Load_Addr,
  input  logic [31:0]           Load_Data
);

  localparam int          DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [3:0]  LAT      = 4'(LATENCY);

  // The wait counter is only 4 bits wide, so larger latencies cannot be honoured.
  generate
    if (LATENCY < 0 || LATENCY > 15) begin : g_latency_check
      $error("inst_mem_responder: LATENCY must be in 0..15");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state;
  logic [31:0]           mem [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_idx;
  logic [ADDR_WIDTH-1:0] req_idx;
  logic                  addr_oor;
  logic                  req_oor;
  logic                  rel_q;
  logic                  accept;
  logic [3:0]            cnt;
  logic [3:0]            eff_lat;
  logic                  unused_pc_bits;

  // Byte address to word index; any set bit above the array is out of range.
  assign req_idx        = PC[ADDR_WIDTH+1:2];
  assign req_oor        = |PC[31:ADDR_WIDTH+2];
  assign unused_pc_bits = ^PC[1:0];

`ifdef INST_MEM_RAND_DELAY_EN
  logic [7:0] lfsr;
  logic [4:0] lat_sum;

  // Fibonacci LFSR (taps 8,6,5,4) free-running to jitter latency and readiness.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr <= 8'hA5;
    else      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  // Extra delay saturates so the 4-bit counter never wraps.
  assign lat_sum        = {1'b0, LAT} + {3'b000, lfsr[1:0]};
  assign eff_lat        = lat_sum[4] ? 4'hF : lat_sum[3:0];
  assign Inst_Req_Ready = (state == IDLE) && rel_q && !lfsr[7];
`else
  assign eff_lat        = LAT;
  assign Inst_Req_Ready = (state == IDLE) && rel_q;
`endif

  assign accept = Inst_Req_Valid && Inst_Req_Ready;

  // Reset release flag: holds off acceptance until one edge after rst rises.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rel_q <= 1'b0;
    else      rel_q <= 1'b1;
  end

  // Backdoor write port; a read of the same word on this edge sees old data.
  always_ff @(posedge clk) begin
    if (Load_En) mem[Load_Addr] <= Load_Data;
  end

  // Request/response FSM; the array is read into Instruction on the edge
  // that enters RESP, and Inst_Valid rises on the following edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      Inst_Valid  <= 1'b0;
      Instruction <= 32'h0;
      cnt         <= 4'd0;
      addr_idx    <= '0;
      addr_oor    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            addr_idx <= req_idx;
            addr_oor <= req_oor;
            cnt      <= eff_lat;
            if (eff_lat == 4'd0) begin
              Instruction <= req_oor ? NOP_INST : mem[req_idx];
              state       <= RESP;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            Instruction <= addr_oor ? NOP_INST : mem[addr_idx];
            state       <= RESP;
          end
        end
        RESP: begin
          if (!Inst_Valid) begin
            Inst_Valid <= 1'b1;
          end else if (Inst_Ready) begin
            Inst_Valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
